// File: rtl/exec_sequencer_if.sv
// Command, status and register-file port bundle for exec_sequencer.
// The master side issues commands and models the register file; the slave side is the sequencer.
interface exec_sequencer_if #(parameter int n = 16);
  logic         start;
  logic [1:0]   op;
  logic [1:0]   shift;
  logic [2:0]   rn;
  logic [2:0]   rm;
  logic [2:0]   rd;
  logic         wb_en;
  logic [n-1:0] rf_data_out;
  logic [2:0]   readnum;
  logic [2:0]   writenum;
  logic         write;
  logic [n-1:0] data_in;
  logic         busy;
  logic         done;
  logic [n-1:0] result;
  logic [2:0]   status;

  modport master (
    output start, op, shift, rn, rm, rd, wb_en, rf_data_out,
    input  readnum, writenum, write, data_in, busy, done, result, status
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, wb_en, rf_data_out,
    output readnum, writenum, write, data_in, busy, done, result, status
  );
endinterface

// File: rtl/exec_sequencer.sv
// Operand-fetch / execute / write-back sequencer around an 8x16 register file.
// One command per start: rd <= op(Rn, shift(Rm)), five cycles from accept to idle.
module exec_sequencer #(
  parameter int n = 16
) (
  input logic            clk,
  input logic            reset,
  exec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t       state, state_nx;
  logic [1:0]   op_q, shift_q;
  logic [2:0]   rn_q, rm_q, rd_q;
  logic         wb_en_q;
  logic [n-1:0] a_q, b_q, c_q;
  logic [2:0]   status_q;
  logic [n-1:0] bs, alu;
  logic         v;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RDA;
      RDA:     state_nx = RDB;
      RDB:     state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q    <= bus.op;
        shift_q <= bus.shift;
        rn_q    <= bus.rn;
        rm_q    <= bus.rm;
        rd_q    <= bus.rd;
        wb_en_q <= bus.wb_en;
      end
      if (state == RDA) a_q <= bus.rf_data_out;
      if (state == RDB) b_q <= bus.rf_data_out;
      if (state == EXEC) begin
        c_q      <= alu;
        status_q <= {v, alu[n-1], (alu == '0)};
      end
    end
  end

  always_comb begin
    bs = b_q;
    case (shift_q)
      2'b01:   bs = {b_q[n-2:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[n-1:1]};
      2'b11:   bs = {b_q[n-1], b_q[n-1:1]};
      default: bs = b_q;
    endcase
  end

  // Overflow is judged on the shifted B operand, the one the adder actually sees.
  always_comb begin
    alu = '0;
    v   = 1'b0;
    case (op_q)
      2'b00: begin
        alu = a_q + bs;
        v   = (a_q[n-1] == bs[n-1]) && (alu[n-1] != a_q[n-1]);
      end
      2'b01: begin
        alu = a_q - bs;
        v   = (a_q[n-1] != bs[n-1]) && (alu[n-1] != a_q[n-1]);
      end
      2'b10:   alu = a_q & bs;
      default: alu = ~bs;
    endcase
  end

  assign bus.readnum  = (state == RDB) ? rm_q : rn_q;
  assign bus.writenum = rd_q;
  assign bus.write    = (state == WB) & wb_en_q & ~reset;
  assign bus.data_in  = c_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == WB);
  assign bus.result   = c_q;
  assign bus.status   = status_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural 8x16 register file.
module tb_exec_sequencer;

  logic clk;
  logic reset;
  logic        pl_we;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] rf [8];
  int total;
  int passed;

  exec_sequencer_if #(.n(16)) bus ();

  exec_sequencer #(.n(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rf_data_out = rf[bus.readnum];

  always @(posedge clk) begin
    if (pl_we)          rf[pl_addr]      <= pl_data;
    else if (bus.write) rf[bus.writenum] <= bus.data_in;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  // Issue one command and check busy/done/write through T+1..T+5; poke pulses start in T+2.
  task automatic run_cmd(input logic [1:0] op_i, input logic [1:0] sh_i,
                         input logic [2:0] rn_i, input logic [2:0] rm_i,
                         input logic [2:0] rd_i, input logic wb_i, input bit poke);
    bus.op    = op_i;
    bus.shift = sh_i;
    bus.rn    = rn_i;
    bus.rm    = rm_i;
    bus.rd    = rd_i;
    bus.wb_en = wb_i;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("busy_t%0d", k), {15'd0, bus.busy}, {15'd0, (k < 5)});
      chk($sformatf("done_t%0d", k), {15'd0, bus.done}, {15'd0, (k == 4)});
      chk($sformatf("write_t%0d", k), {15'd0, bus.write}, {15'd0, (wb_i && k == 4)});
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.rd    = 3'd7;
        bus.wb_en = 1'b0;
      end
      if (k < 5) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = op_i;
        bus.rd    = rd_i;
        bus.wb_en = wb_i;
      end
    end
    @(posedge clk);
    #1;
    chk("busy_idle_after", {15'd0, bus.busy}, 16'd0);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    pl_we     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.shift = '0;
    bus.rn    = '0;
    bus.rm    = '0;
    bus.rd    = '0;
    bus.wb_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy",   {15'd0, bus.busy},  16'd0);
    chk("rst_done",   {15'd0, bus.done},  16'd0);
    chk("rst_write",  {15'd0, bus.write}, 16'd0);
    chk("rst_result", bus.result,         16'h0000);
    chk("rst_status", {13'd0, bus.status}, 16'd0);

    // add 5 + 3 -> R3
    preload(3'd1, 16'd5);
    preload(3'd2, 16'd3);
    preload(3'd3, 16'hDEAD);
    run_cmd(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    chk("add_result", bus.result, 16'd8);
    chk("add_status", {13'd0, bus.status}, 16'd0);
    chk("add_r3",     rf[3],      16'd8);

    // sub 3 - 3 -> R4, zero flag
    preload(3'd1, 16'd3);
    preload(3'd4, 16'h1234);
    run_cmd(2'b01, 2'b00, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0);
    chk("sub0_r4",     rf[4], 16'h0000);
    chk("sub0_status", {13'd0, bus.status}, 16'b001);

    // signed overflow on add and sub
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run_cmd(2'b00, 2'b00, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("addv_result", bus.result, 16'h8000);
    chk("addv_status", {13'd0, bus.status}, 16'b110);
    chk("addv_r5",     rf[5], 16'h8000);
    preload(3'd1, 16'h8000);
    run_cmd(2'b01, 2'b00, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("subv_result", bus.result, 16'h7FFF);
    chk("subv_status", {13'd0, bus.status}, 16'b100);

    // shifter paths
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h8004);
    run_cmd(2'b10, 2'b11, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("and_asr_result", bus.result, 16'hC002);
    chk("and_asr_status", {13'd0, bus.status}, 16'b010);
    run_cmd(2'b11, 2'b01, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("not_lsl_result", bus.result, 16'hFFF7);
    chk("not_lsl_r5",     rf[5], 16'hFFF7);
    run_cmd(2'b10, 2'b10, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    chk("and_lsr_result", bus.result, 16'h4002);
    chk("and_lsr_status", {13'd0, bus.status}, 16'b000);

    // start during a command is ignored; latched command is not disturbed
    preload(3'd7, 16'hAAAA);
    run_cmd(2'b00, 2'b00, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1);
    chk("poke_result", bus.result, 16'h8003);
    chk("poke_r6",     rf[6], 16'h8003);
    chk("poke_r7",     rf[7], 16'hAAAA);

    // compute-only command: flags update, rd untouched
    run_cmd(2'b01, 2'b00, 3'd1, 3'd2, 3'd6, 1'b0, 1'b0);
    chk("nowb_result", bus.result, 16'h7FFB);
    chk("nowb_status", {13'd0, bus.status}, 16'b000);
    chk("nowb_r6",     rf[6], 16'h8003);

    // reset in WB
    bus.op    = 2'b00;
    bus.shift = 2'b00;
    bus.rn    = 3'd1;
    bus.rm    = 3'd2;
    bus.rd    = 3'd7;
    bus.wb_en = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wbrst_done_pre",  {15'd0, bus.done},  16'd1);
    chk("wbrst_write_pre", {15'd0, bus.write}, 16'd1);
    chk("wbrst_c_pre",     bus.result, 16'h8003);
    reset = 1'b1;
    #1;
    chk("wbrst_write_forced", {15'd0, bus.write}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("wbrst_busy",   {15'd0, bus.busy}, 16'd0);
    chk("wbrst_result", bus.result, 16'h0000);
    chk("wbrst_status", {13'd0, bus.status}, 16'd0);
    chk("wbrst_r7",     rf[7], 16'hAAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
